// File: rtl/fpadd_param.sv
// fpadd_param: multi-cycle floating-point adder/subtractor with parametrised
// exponent/fraction widths, round-to-nearest-even and exception flags.
// Subnormal inputs are flushed to signed zero.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, op, a, b       launch (sampled in IDLE when not busy); op=1 -> a-b
//   sum                   result word, held until the next operation completes
//   done                  one-cycle pulse when sum/flags are valid
//   busy                  high from the cycle after accept through the done cycle
//   ovf, invalid, inexact exception flags, cleared on accept, written at PACK
module fpadd_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         done,
    output logic         busy,
    output logic         ovf,
    output logic         invalid,
    output logic         inexact
);
    // Significand layout: [SW-1] carry, [SW-2] hidden, fraction, then G/R/S.
    localparam int SW = MAN_W + 5;
    localparam int EW = EXP_W + 1;  // one spare bit to see exponent overflow
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK
    } state_t;

    state_t         state;
    logic [W-1:0]   a_r, b_r;
    logic           sa, sb;
    logic [EW-1:0]  ea, eb;
    logic [SW-1:0]  ma, mb;
    logic [W-1:0]   res_word;   // complete result for special/zero paths
    logic           bypass;
    logic           inv_p, inx_p;

    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] frac_a, frac_b;
    logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [EW-1:0]    diff;
    logic [SW-1:0]    addsum;
    logic             rinc;
    logic [MAN_W+1:0] rnd;

    assign exp_a  = a_r[W-2:MAN_W];
    assign exp_b  = b_r[W-2:MAN_W];
    assign frac_a = a_r[MAN_W-1:0];
    assign frac_b = b_r[MAN_W-1:0];
    assign nan_a  = (exp_a == EMAX) && (frac_a != '0);
    assign nan_b  = (exp_b == EMAX) && (frac_b != '0);
    assign inf_a  = (exp_a == EMAX) && (frac_a == '0);
    assign inf_b  = (exp_b == EMAX) && (frac_b == '0);
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);

    assign diff   = ea - eb;
    // After the swap A >= B in magnitude, so the difference never goes negative.
    assign addsum = (sa == sb) ? ma + mb : ma - mb;
    assign rinc   = ma[2] & (ma[1] | ma[0] | ma[3]);
    assign rnd    = {1'b0, ma[SW-2:3]} + {{(MAN_W+1){1'b0}}, rinc};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            ea       <= '0;
            eb       <= '0;
            ma       <= '0;
            mb       <= '0;
            res_word <= '0;
            bypass   <= 1'b0;
            inv_p    <= 1'b0;
            inx_p    <= 1'b0;
            sum      <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
            invalid  <= 1'b0;
            inexact  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    // busy is still high in the done cycle, so a start there is dropped
                    if (start && !busy) begin
                        a_r     <= a;
                        b_r     <= {b[W-1] ^ op, b[W-2:0]};
                        busy    <= 1'b1;
                        ovf     <= 1'b0;
                        invalid <= 1'b0;
                        inexact <= 1'b0;
                        bypass  <= 1'b0;
                        inv_p   <= 1'b0;
                        inx_p   <= 1'b0;
                        state   <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sa    <= a_r[W-1];
                    sb    <= b_r[W-1];
                    ea    <= {1'b0, exp_a};
                    eb    <= {1'b0, exp_b};
                    ma    <= zero_a ? '0 : {2'b01, frac_a, 3'b000};
                    mb    <= zero_b ? '0 : {2'b01, frac_b, 3'b000};
                    state <= S_SPECIAL;
                end
                S_SPECIAL: begin
                    bypass <= 1'b1;
                    state  <= S_PACK;
                    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
                        res_word <= QNAN;
                        inv_p    <= 1'b1;
                    end else if (inf_a) begin
                        res_word <= a_r;
                    end else if (inf_b) begin
                        res_word <= b_r;
                    end else if (zero_a && zero_b) begin
                        res_word <= {sa & sb, {(W-1){1'b0}}};
                    end else if (zero_a) begin
                        res_word <= b_r;
                    end else if (zero_b) begin
                        res_word <= a_r;
                    end else begin
                        // Larger magnitude goes to A before alignment starts.
                        bypass <= 1'b0;
                        state  <= S_ALIGN;
                        if ({ea, ma} < {eb, mb}) begin
                            sa <= sb;  sb <= sa;
                            ea <= eb;  eb <= ea;
                            ma <= mb;  mb <= ma;
                        end
                    end
                end
                S_ALIGN: begin
                    if (diff == '0) begin
                        state <= S_ADD;
                    end else if (32'(diff) > 32'(MAN_W + 3)) begin
                        // Everything shifts out: B survives only as sticky.
                        mb    <= {{(SW-1){1'b0}}, |mb};
                        eb    <= ea;
                        state <= S_ADD;
                    end else begin
                        mb <= {1'b0, mb[SW-1:2], mb[1] | mb[0]};
                        eb <= eb + 1'b1;
                        if (diff == EW'(1)) state <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (addsum == '0) begin
                        res_word <= '0;
                        bypass   <= 1'b1;
                        state    <= S_PACK;
                    end else begin
                        ma    <= addsum;
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (ma[SW-1]) begin
                        ma    <= {1'b0, ma[SW-1:2], ma[1] | ma[0]};
                        ea    <= ea + 1'b1;
                        state <= S_ROUND;
                    end else if (ma[SW-2]) begin
                        state <= S_ROUND;
                    end else if (ea == EW'(1)) begin
                        // Would go subnormal: flush.
                        res_word <= {sa, {(W-1){1'b0}}};
                        bypass   <= 1'b1;
                        inx_p    <= 1'b1;
                        state    <= S_PACK;
                    end else begin
                        ma <= ma << 1;
                        ea <= ea - 1'b1;
                    end
                end
                S_ROUND: begin
                    inx_p <= |ma[2:0];
                    if (rnd[MAN_W+1]) begin
                        // 1.11..1 rounded up to 10.00..0: renormalise here.
                        ma <= {2'b01, {MAN_W{1'b0}}, 3'b000};
                        ea <= ea + 1'b1;
                    end else begin
                        ma <= {1'b0, rnd[MAN_W:0], 3'b000};
                    end
                    state <= S_PACK;
                end
                S_PACK: begin
                    invalid <= inv_p;
                    if (bypass) begin
                        sum     <= res_word;
                        inexact <= inx_p;
                    end else if (ea >= {1'b0, EMAX}) begin
                        sum     <= {sa, EMAX, {MAN_W{1'b0}}};
                        ovf     <= 1'b1;
                        inexact <= 1'b1;
                    end else begin
                        sum     <= {sa, ea[EXP_W-1:0], ma[MAN_W+2:3]};
                        inexact <= inx_p;
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpadd_param.sv
// Scoreboard bench for fpadd_param: an FP32 instance and an FP16-style
// (EXP_W=5, MAN_W=10) instance. Drivers push hand-computed expectations;
// a monitor pops and compares on every done pulse.
module tb_fpadd_param;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, op, done, busy, ovf, invalid, inexact;
    logic [31:0] a, b, sum;
    logic        h_start, h_op, h_done, h_busy, h_ovf, h_invalid, h_inexact;
    logic [15:0] h_a, h_b, h_sum;

    always #5 clk = ~clk;

    fpadd_param #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .sum(sum), .done(done), .busy(busy), .ovf(ovf), .invalid(invalid),
        .inexact(inexact));

    fpadd_param #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset_n(reset_n), .start(h_start), .op(h_op), .a(h_a),
        .b(h_b), .sum(h_sum), .done(h_done), .busy(h_busy), .ovf(h_ovf),
        .invalid(h_invalid), .inexact(h_inexact));

    typedef struct {
        logic [31:0] sum;
        logic [2:0]  fl;   // {ovf, invalid, inexact}
        string       tag;
    } exp_t;

    exp_t q[$];
    exp_t hq[$];
    exp_t me, mh;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented result against the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                me = q.pop_front();
                check({me.tag, "_sum"}, sum, me.sum);
                check({me.tag, "_flags"}, {29'd0, ovf, invalid, inexact}, {29'd0, me.fl});
            end
        end
        if (h_done === 1'b1) begin
            if (hq.size() == 0) begin
                check("h_unexpected_done", 32'(h_done), 32'd0);
            end else begin
                mh = hq.pop_front();
                check({mh.tag, "_sum"}, {16'd0, h_sum}, mh.sum);
                check({mh.tag, "_flags"}, {29'd0, h_ovf, h_invalid, h_inexact}, {29'd0, mh.fl});
            end
        end
    end

    // Launch one FP32 operation and wait for done. With intrude set, a
    // different start is asserted mid-operation and again in the done cycle.
    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic top, input logic [31:0] es, input logic [2:0] ef,
                         input bit intrude, output int cyc);
        bit got, busy_ok;
        q.push_back('{es, ef, tag});
        @(negedge clk);
        a = ta; b = tb; op = top; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; got = 0; busy_ok = 1;
        while (cyc < 100) begin
            if (busy !== 1'b1) busy_ok = 0;
            if (done === 1'b1) begin
                got = 1;
                break;
            end
            if (intrude && cyc == 2) begin
                a = 32'h40400000; b = 32'h3F800000; op = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
        if (got) begin
            if (intrude) begin
                a = 32'h40400000; b = 32'h3F800000; op = 1'b0; start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            check({tag, "_done_single"}, 32'(done), 32'd0);
            check({tag, "_busy_after"}, 32'(busy), 32'd0);
            if (intrude) begin
                repeat (20) @(negedge clk);
                check({tag, "_late_start_ignored"}, 32'(busy), 32'd0);
            end
        end else begin
            q.delete(q.size() - 1);
        end
    endtask

    task automatic do_h(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic top, input logic [15:0] es, input logic [2:0] ef);
        bit got;
        hq.push_back('{{16'd0, es}, ef, tag});
        @(negedge clk);
        h_a = ta; h_b = tb; h_op = top; h_start = 1'b1;
        @(negedge clk);
        h_start = 1'b0;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            if (h_done === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        if (!got) hq.delete(hq.size() - 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int cyc;
        start = 0; op = 0; a = 0; b = 0;
        h_start = 0; h_op = 0; h_a = 0; h_b = 0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("rst_sum", sum, 32'd0);
        check("rst_ctl", {27'd0, done, busy, ovf, invalid, inexact}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        do_op("add_1_1",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 0, cyc);
        do_op("sub_1_1",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 0, cyc);
        do_op("sub_3_1",   32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 0, cyc);
        do_op("tie_even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 0, cyc);
        do_op("tie_odd",   32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001, 0, cyc);
        do_op("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b101, 0, cyc);
        do_op("inf_m_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b010, 0, cyc);
        do_op("nan_in",    32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b010, 0, cyc);
        do_op("big_gap",   32'h4B800000, 32'h00800000, 1'b0, 32'h4B800000, 3'b001, 0, cyc);
        check("big_gap_latency_ok", 32'(cyc <= 10), 32'd1);
        do_h("h_add_1_1", 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000);

        // start while busy and in the done cycle must not disturb the result
        do_op("busy_intrude", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 1, cyc);

        // Abort in ALIGN (exponent gap 24 keeps it there for many cycles)
        @(negedge clk);
        a = 32'h4B800000; b = 32'h3F800000; op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_sum", sum, 32'd0);
        check("abort_ctl", {27'd0, done, busy, ovf, invalid, inexact}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_busy", 32'(busy), 32'd0);

        do_op("post_reset", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000, 0, cyc);

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(q.size() + hq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
